// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment scroll controller: register map,
// CTRL/STATUS bit positions, FSM encoding and the active-high hex glyph table.
package sev_seg_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_LENGTH = 3'd3;
  localparam logic [2:0] ADDR_MSG_LO = 3'd4;
  localparam logic [2:0] ADDR_MSG_HI = 3'd5;
  localparam logic [2:0] ADDR_BLINK  = 3'd6;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_LOOP      = 1;
  localparam int CTRL_BLANK     = 2;
  localparam int CTRL_BLINK_EN  = 3;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_POS_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Segment a is bit 0, g is bit 6; a set bit means the segment is lit.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to seven-segment glyph decoder with a blank override and selectable
// output polarity (active-low for the DE1 HEX displays).
module hex_to_seg7
  import sev_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] lit;

  always_comb begin
    lit = blank ? SEG_BLANK : hex_glyph(hex);
    seg = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/sev_seg_scroll_ctrl.sv
// Avalon-MM seven-segment scroller: steps a 4-character window across a message
// of up to 16 hex chars. Define SEV_SEG_SCROLL_BLINK_EN to add the blink feature.
module sev_seg_scroll_ctrl
  import sev_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int PERIOD_W       = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [27:0] out_port
);

  localparam logic [27:0] OUT_BLANK = SEG_ACTIVE_LOW ? 28'hFFF_FFFF : 28'h000_0000;

  state_t state, state_next;

  logic                ctrl_run, ctrl_loop, ctrl_blank;
  logic                done;
  logic [PERIOD_W-1:0] period, prescaler;
  logic [3:0]          length, pos;
  logic [31:0]         msg_lo, msg_hi;

  logic wr_en, wr_ctrl, wr_status, wr_period, wr_length;
  logic busy, step, at_last, restart, enter_done;
  logic display_off;

  logic [63:0] msg;
  logic [4:0]  len;
  logic [4:0]  char_idx   [4];
  logic [3:0]  digit_char [4];
  logic        digit_off  [4];
  logic [27:0] seg_next;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_status = wr_en && (address == ADDR_STATUS);
  assign wr_period = wr_en && (address == ADDR_PERIOD);
  assign wr_length = wr_en && (address == ADDR_LENGTH);
  assign at_last   = (pos == length);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // A CTRL write always takes priority over a scroll step on the same clock.
  always_comb begin
    state_next = state;
    if (wr_ctrl) begin
      if (writedata[CTRL_RUN])  state_next = ST_RUN;
      else if (state == ST_RUN) state_next = ST_IDLE;
    end else if (enter_done) begin
      state_next = ST_DONE;
    end
  end

  always_comb begin
    busy       = (state == ST_RUN);
    step       = busy && (prescaler == period) && !wr_ctrl && !wr_period;
    restart    = wr_ctrl && writedata[CTRL_RUN] && (state != ST_RUN);
    enter_done = step && at_last && !ctrl_loop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if ((state_next != ST_RUN) || restart || wr_period) begin
      prescaler <= '0;
    end else if (!wr_ctrl) begin
      prescaler <= (prescaler == period) ? '0 : prescaler + PERIOD_W'(1);
    end
  end

  // Shrinking LENGTH below the current position snaps the window back to char 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              pos <= '0;
    else if (restart)                          pos <= '0;
    else if (wr_length && (pos > writedata[3:0])) pos <= '0;
    else if (step && !at_last)                 pos <= pos + 4'd1;
    else if (step && ctrl_loop)                pos <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run   <= 1'b0;
      ctrl_loop  <= 1'b0;
      ctrl_blank <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_run   <= writedata[CTRL_RUN];
      ctrl_loop  <= writedata[CTRL_LOOP];
      ctrl_blank <= writedata[CTRL_BLANK];
    end else if (enter_done) begin
      ctrl_run   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  done <= 1'b0;
    else if (enter_done)                           done <= 1'b1;
    else if (wr_status && writedata[STATUS_DONE]) done <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
      length <= '0;
      msg_lo <= '0;
      msg_hi <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_PERIOD: period <= writedata[PERIOD_W-1:0];
        ADDR_LENGTH: length <= writedata[3:0];
        ADDR_MSG_LO: msg_lo <= writedata;
        ADDR_MSG_HI: msg_hi <= writedata;
        default: ;
      endcase
    end
  end

`ifdef SEV_SEG_SCROLL_BLINK_EN
  logic                blink_en, blink_phase;
  logic [PERIOD_W-1:0] blink, blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en <= 1'b0;
      blink    <= '0;
    end else begin
      if (wr_ctrl)                                blink_en <= writedata[CTRL_BLINK_EN];
      if (wr_en && (address == ADDR_BLINK))       blink    <= writedata[PERIOD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wr_ctrl && !writedata[CTRL_BLINK_EN]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt   <= '0;
    end else if (blink_cnt == blink) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + PERIOD_W'(1);
    end
  end

  assign display_off = ctrl_blank | blink_phase;
`else
  assign display_off = ctrl_blank;
`endif

  // Digit d shows char pos+(3-d); three conditional subtractions cover every
  // reachable index since pos never exceeds LEN-1.
  always_comb begin
    msg = {msg_hi, msg_lo};
    len = {1'b0, length} + 5'd1;
    for (int d = 0; d < 4; d++) begin
      char_idx[d] = {1'b0, pos} + 5'(3 - d);
      if (ctrl_loop) begin
        for (int r = 0; r < 3; r++) begin
          if (char_idx[d] >= len) char_idx[d] = char_idx[d] - len;
        end
      end
      digit_off[d]  = display_off || (char_idx[d] >= len);
      digit_char[d] = msg[{char_idx[d][3:0], 2'b00} +: 4];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_digit
    hex_to_seg7 #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .hex  (digit_char[g]),
      .blank(digit_off[g]),
      .seg  (seg_next[g*7 +: 7])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= OUT_BLANK;
    else          out_port <= seg_next;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN]   = ctrl_run;
        readdata[CTRL_LOOP]  = ctrl_loop;
        readdata[CTRL_BLANK] = ctrl_blank;
`ifdef SEV_SEG_SCROLL_BLINK_EN
        readdata[CTRL_BLINK_EN] = blink_en;
`endif
      end
      ADDR_STATUS: begin
        readdata[STATUS_BUSY]            = busy;
        readdata[STATUS_DONE]            = done;
        readdata[STATUS_POS_LSB +: 4]    = pos;
      end
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
      ADDR_LENGTH: readdata[3:0]          = length;
      ADDR_MSG_LO: readdata               = msg_lo;
      ADDR_MSG_HI: readdata               = msg_hi;
`ifdef SEV_SEG_SCROLL_BLINK_EN
      ADDR_BLINK:  readdata[PERIOD_W-1:0] = blink;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sev_seg_scroll_ctrl.sv
// Scoreboard bench for sev_seg_scroll_ctrl: a behavioural model predicts
// out_port and readdata each cycle; a separate monitor pops and compares.
`timescale 1ns/1ps
module tb_sev_seg_scroll_ctrl;

  localparam logic [31:0] PERIOD_MASK = 32'h00FF_FFFF;
`ifdef SEV_SEG_SCROLL_BLINK_EN
  localparam bit HAS_BLINK = 1'b1;
`else
  localparam bit HAS_BLINK = 1'b0;
`endif

  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [27:0] out_port;

  always #5 clk = ~clk;

  sev_seg_scroll_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  typedef struct {
    string       name;
    logic [31:0] expected;
    bit          is_out;
  } chk_t;

  chk_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the programmer-visible state.
  bit          m_ctrl_run, m_loop, m_blank, m_done, m_running;
  int          m_period, m_len, m_pos, m_tick;
  logic [31:0] m_msg_lo, m_msg_hi, m_blink_reg;
  logic [27:0] m_out;

  function automatic void model_reset();
    m_ctrl_run = 0; m_loop = 0; m_blank = 0; m_done = 0; m_running = 0;
    m_period = 0; m_len = 1; m_pos = 0; m_tick = 0;
    m_msg_lo = '0; m_msg_hi = '0; m_blink_reg = '0;
    m_out = 28'hFFF_FFFF;
  endfunction

  function automatic logic [27:0] model_window();
    logic [27:0] r;
    logic [63:0] msg;
    logic [6:0]  g;
    int          idx;
    msg = {m_msg_hi, m_msg_lo};
    for (int d = 0; d < 4; d++) begin
      idx = m_pos + 3 - d;
      g   = 7'h00;
      if (m_loop) idx = idx % m_len;
      if (!m_blank && idx < m_len) g = GLYPH_TAB[msg[idx*4 +: 4]];
      r[d*7 +: 7] = ~g;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {29'd0, m_blank, m_loop, m_ctrl_run};
      3'd1: return 32'(m_pos) * 16 + {30'd0, m_done, m_running};
      3'd2: return 32'(m_period);
      3'd3: return 32'(m_len - 1);
      3'd4: return m_msg_lo;
      3'd5: return m_msg_hi;
      3'd6: return HAS_BLINK ? m_blink_reg : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_advance(input bit wr, input logic [2:0] a, input logic [31:0] d);
    logic [27:0] nxt_out;
    bit ctrl_w, per_w, stepping, finishing;
    int old_pos;
    nxt_out   = model_window();
    ctrl_w    = wr && a == 3'd0;
    per_w     = wr && a == 3'd2;
    stepping  = m_running && m_tick == m_period && !ctrl_w && !per_w;
    finishing = 0;
    old_pos   = m_pos;
    if (ctrl_w) begin
      m_ctrl_run = d[0]; m_loop = d[1]; m_blank = d[2];
      if (d[0] && !m_running) begin
        m_pos = 0; m_tick = 0; m_running = 1;
      end else if (!d[0] && m_running) begin
        m_running = 0; m_tick = 0;
      end
    end else if (per_w) begin
      m_period = int'(d & PERIOD_MASK);
      m_tick   = 0;
    end else if (stepping) begin
      m_tick = 0;
      if (m_pos < m_len - 1) m_pos = m_pos + 1;
      else if (m_loop)       m_pos = 0;
      else begin
        m_running = 0; m_ctrl_run = 0; finishing = 1;
      end
    end else if (m_running) begin
      m_tick = m_tick + 1;
    end
    if (wr && a == 3'd1 && d[1]) m_done = 0;
    if (finishing) m_done = 1;
    if (wr && a == 3'd3) begin
      m_len = int'(d[3:0]) + 1;
      if (old_pos > m_len - 1) m_pos = 0;
    end
    if (wr && a == 3'd4) m_msg_lo = d;
    if (wr && a == 3'd5) m_msg_hi = d;
    if (wr && a == 3'd6 && HAS_BLINK) m_blink_reg = d & PERIOD_MASK;
    m_out = nxt_out;
  endfunction

  // One bus cycle: drive, queue the expected responses, advance the model.
  task automatic applyStimulus(input bit wr, input logic [2:0] a, input logic [31:0] d);
    chk_t c;
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
    c.name = "out_port"; c.expected = {4'h0, m_out}; c.is_out = 1'b1;
    sb_q.push_back(c);
    if (!wr) begin
      c.name = $sformatf("readdata[addr %0d]", a); c.expected = model_read(a); c.is_out = 1'b0;
      sb_q.push_back(c);
    end
    if (reset_n) model_advance(wr, a, d);
  endtask

  task automatic checkOutput(input chk_t c);
    logic [31:0] actual;
    actual = c.is_out ? {4'h0, out_port} : readdata;
    checks++;
    if (actual !== c.expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", c.name, $time, actual, c.expected);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  task automatic applyReset(input int cycles);
    @(negedge clk);
    #3 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 3'(i % 8), 32'd0);
    #3 reset_n = 1'b1;
    model_advance(1'b0, address, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'(i % 2), 32'd0);
  endtask

  // Idles until the model predicts a scroll step on the coming edge.
  task automatic waitStep(input bit want_last, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (m_running && m_tick == m_period && (!want_last || m_pos == m_len - 1)) return;
      applyStimulus(1'b0, 3'd1, 32'd0);
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_step: no scroll step within %0d cycles, one was required", budget);
  endtask

  initial begin : driver
    logic [31:0] d;
    int r;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    model_reset();
    applyReset(8);

    // Static display of chars 1,2,3,4.
    applyStimulus(1'b1, 3'd4, 32'h0000_4321);
    applyStimulus(1'b1, 3'd3, 32'd3);
    applyStimulus(1'b1, 3'd0, 32'd0);
    idle(3);

    // One-shot scroll over six chars.
    applyStimulus(1'b1, 3'd4, 32'h7654_3210);
    applyStimulus(1'b1, 3'd2, 32'd4);
    applyStimulus(1'b1, 3'd3, 32'd5);
    applyStimulus(1'b1, 3'd0, 32'd1);
    idle(40);

    // Looping three-char message stepping every clock, then reset mid-run.
    applyStimulus(1'b1, 3'd4, 32'h0000_0CBA);
    applyStimulus(1'b1, 3'd3, 32'd2);
    applyStimulus(1'b1, 3'd2, 32'd0);
    applyStimulus(1'b1, 3'd0, 32'd3);
    idle(8);
    applyReset(8);

    // CTRL write colliding with a step: the step is dropped.
    applyStimulus(1'b1, 3'd4, 32'h8765_4321);
    applyStimulus(1'b1, 3'd3, 32'd7);
    applyStimulus(1'b1, 3'd2, 32'd3);
    applyStimulus(1'b1, 3'd0, 32'd1);
    waitStep(1'b0, 20);
    applyStimulus(1'b1, 3'd0, 32'd1);
    idle(6);

    // Done-clear colliding with done being set: set wins.
    applyStimulus(1'b1, 3'd0, 32'd0);
    applyStimulus(1'b1, 3'd3, 32'd0);
    applyStimulus(1'b1, 3'd2, 32'd2);
    applyStimulus(1'b1, 3'd0, 32'd1);
    waitStep(1'b1, 20);
    applyStimulus(1'b1, 3'd1, 32'd2);
    applyStimulus(1'b0, 3'd1, 32'd0);
    applyStimulus(1'b1, 3'd1, 32'd2);
    applyStimulus(1'b0, 3'd1, 32'd0);

    // Randomised register traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        applyStimulus(1'b0, 3'($urandom_range(0, 7)), 32'd0);
      end else if (r < 67) begin
        d = $urandom & 32'hF;
        d[0] = ($urandom_range(0, 3) != 0);
        d[2] = ($urandom_range(0, 3) == 0);
        if (HAS_BLINK) d[3] = 1'b0;
        applyStimulus(1'b1, 3'd0, d);
      end else if (r < 72) begin
        applyStimulus(1'b1, 3'd1, $urandom);
      end else if (r < 79) begin
        d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
        applyStimulus(1'b1, 3'd2, d);
      end else if (r < 86) begin
        applyStimulus(1'b1, 3'd3, $urandom);
      end else if (r < 95) begin
        applyStimulus(1'b1, 3'($urandom_range(4, 5)), $urandom);
      end else begin
        applyStimulus(1'b1, 3'($urandom_range(6, 7)), $urandom);
      end
    end
    idle(4);

    @(negedge clk);
    #4;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, 0 required", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
